// File: rtl/warp_dispatch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : warp_dispatch_scheduler_if
// Brief    : Request, issue, completion and status bundle of the warp scheduler.
//            Optional stat_* signals exist only with WARP_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
interface warp_dispatch_scheduler_if #(
    parameter int NUM_CORES    = 4,
    parameter int QUEUE_DEPTH  = 8,
    parameter int NUM_WARP_IDS = 15,
    parameter int THREAD_W     = 3,
    parameter int PC_W         = 32
);
    localparam int ID_W   = $clog2(NUM_WARP_IDS + 1);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);

    logic                          launch_en;
    logic [NUM_CORES-1:0]          req_valid;
    logic [NUM_CORES*THREAD_W-1:0] req_thread_count;
    logic [NUM_CORES*PC_W-1:0]     req_pc;
    logic [NUM_CORES-1:0]          req_ready;
    logic                          kernel_valid;
    logic                          kernel_ready;
    logic [THREAD_W-1:0]           kernel_thread_count;
    logic [PC_W-1:0]               kernel_start_pc;
    logic [ID_W-1:0]               kernel_warp_id;
    logic                          free_valid;
    logic [ID_W-1:0]               free_warp_id;
    logic [QCNT_W-1:0]             queue_count;
    logic [ID_W-1:0]               ids_busy;
    logic                          drop_pulse;
    logic                          free_err;
`ifdef WARP_SCHED_STATS_EN
    logic [31:0]                   stat_issued;
    logic [31:0]                   stat_stall;
`endif

    modport master (
        output launch_en, req_valid, req_thread_count, req_pc,
        output kernel_ready, free_valid, free_warp_id,
`ifdef WARP_SCHED_STATS_EN
        input  stat_issued, stat_stall,
`endif
        input  req_ready, kernel_valid, kernel_thread_count, kernel_start_pc,
        input  kernel_warp_id, queue_count, ids_busy, drop_pulse, free_err
    );

    modport slave (
        input  launch_en, req_valid, req_thread_count, req_pc,
        input  kernel_ready, free_valid, free_warp_id,
`ifdef WARP_SCHED_STATS_EN
        output stat_issued, stat_stall,
`endif
        output req_ready, kernel_valid, kernel_thread_count, kernel_start_pc,
        output kernel_warp_id, queue_count, ids_busy, drop_pulse, free_err
    );
endinterface
`default_nettype wire

// File: rtl/warp_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : warp_dispatch_scheduler
// Brief    : Round-robin kernel ingest into a FIFO, warp-ID allocation and
//            valid/ready issue. WARP_SCHED_STATS_EN adds issue/stall counters.
// Revision : 1.0
// ============================================================================
module warp_dispatch_scheduler #(
    parameter int NUM_CORES    = 4,
    parameter int QUEUE_DEPTH  = 8,
    parameter int NUM_WARP_IDS = 15,
    parameter int THREAD_W     = 3,
    parameter int PC_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    warp_dispatch_scheduler_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_WARP_IDS + 1);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int QPTR_W = $clog2(QUEUE_DEPTH);
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [ID_W-1:0]   c_ID_NONE   = {ID_W{1'b1}};
    localparam logic [QCNT_W-1:0] c_QDEPTH    = QCNT_W'(QUEUE_DEPTH);
    localparam logic [CORE_W:0]   c_NCORES    = (CORE_W + 1)'(NUM_CORES);
    localparam logic [CORE_W-1:0] c_LAST_CORE = CORE_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_kvalid;
    logic [PC_W-1:0]         r_kpc;
    logic [THREAD_W-1:0]     r_ktc;
    logic [ID_W-1:0]         r_kid;

    logic [CORE_W-1:0]       r_rr_ptr;
    logic [PC_W-1:0]         r_fifo_pc [QUEUE_DEPTH];
    logic [THREAD_W-1:0]     r_fifo_tc [QUEUE_DEPTH];
    logic [QPTR_W-1:0]       r_wr_ptr;
    logic [QPTR_W-1:0]       r_rd_ptr;
    logic [QCNT_W-1:0]       r_count;
    logic [NUM_WARP_IDS-1:0] r_busy;
    logic [ID_W-1:0]         r_ids_busy;
    logic                    r_free_err;

    logic [NUM_CORES-1:0]    w_req_rot;
    logic                    w_arb_hit;
    logic [CORE_W-1:0]       w_arb_off;
    logic [CORE_W:0]         w_arb_sum;
    logic [CORE_W-1:0]       w_arb_win;
    logic [PC_W-1:0]         w_sel_pc;
    logic [THREAD_W-1:0]     w_sel_tc;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_xfer;
    logic                    w_push;
    logic                    w_drop;
    logic [NUM_CORES-1:0]    w_grant;

    logic [NUM_WARP_IDS-1:0] w_free_mask;
    logic                    w_free_ok;
    logic                    w_free_bad;
    logic                    w_id_avail;
    logic [ID_W-1:0]         w_alloc_id;
    logic                    w_pop;
    logic [NUM_WARP_IDS-1:0] w_alloc_mask;

    // Rotate so that bit 0 is the current highest-priority core.
    assign w_req_rot = NUM_CORES'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_off = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_arb_hit = 1'b1;
                w_arb_off = CORE_W'(k);
            end
        end
    end

    assign w_arb_sum = {1'b0, r_rr_ptr} + {1'b0, w_arb_off};
    assign w_arb_win = (w_arb_sum >= c_NCORES) ? CORE_W'(w_arb_sum - c_NCORES)
                                               : w_arb_sum[CORE_W-1:0];

    always_comb begin
        w_sel_pc = '0;
        w_sel_tc = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_arb_win == CORE_W'(k)) begin
                w_sel_pc = bus.req_pc[k*PC_W +: PC_W];
                w_sel_tc = bus.req_thread_count[k*THREAD_W +: THREAD_W];
            end
        end
    end

    assign w_full  = (r_count == c_QDEPTH);
    assign w_empty = (r_count == '0);
    assign w_xfer  = w_arb_hit && !w_full && !rst;
    assign w_push  = w_xfer && (w_sel_tc != '0);
    assign w_drop  = w_xfer && (w_sel_tc == '0);
    assign w_grant = w_xfer ? (NUM_CORES'(1) << w_arb_win) : '0;

    // Only IDs already busy before this edge may be freed.
    always_comb begin
        w_free_mask = '0;
        for (int i = 0; i < NUM_WARP_IDS; i++) begin
            if (bus.free_valid && (bus.free_warp_id == ID_W'(i)) && r_busy[i]) begin
                w_free_mask[i] = 1'b1;
            end
        end
    end

    assign w_free_ok  = |w_free_mask;
    assign w_free_bad = bus.free_valid && !w_free_ok;

    // Allocation looks at the registered bitmap, so a same-cycle free is not yet visible.
    always_comb begin
        w_id_avail = 1'b0;
        w_alloc_id = '0;
        for (int i = NUM_WARP_IDS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_id_avail = 1'b1;
                w_alloc_id = ID_W'(i);
            end
        end
    end

    assign w_pop        = (r_state == ST_LOAD) && w_id_avail;
    assign w_alloc_mask = w_pop ? (NUM_WARP_IDS'(1) << w_alloc_id) : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr] <= w_sel_pc;
            r_fifo_tc[r_wr_ptr] <= w_sel_tc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_busy     <= '0;
            r_ids_busy <= '0;
            r_free_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_arb_win == c_LAST_CORE) ? '0 : w_arb_win + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= r_count + QCNT_W'(w_push) - QCNT_W'(w_pop);
            r_busy     <= (r_busy & ~w_free_mask) | w_alloc_mask;
            r_ids_busy <= r_ids_busy + ID_W'(w_pop) - ID_W'(w_free_ok);
            if (w_free_bad) begin
                r_free_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_kvalid <= 1'b0;
            r_kpc    <= '0;
            r_ktc    <= '0;
            r_kid    <= c_ID_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && bus.launch_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_id_avail) begin
                        r_kvalid <= 1'b1;
                        r_kpc    <= r_fifo_pc[r_rd_ptr];
                        r_ktc    <= r_fifo_tc[r_rd_ptr];
                        r_kid    <= w_alloc_id;
                        r_state  <= ST_ISSUE;
                    end else begin
                        r_state <= ST_STALL;
                    end
                end
                ST_ISSUE: begin
                    // launch_en only matters once the held kernel is taken.
                    if (bus.kernel_ready) begin
                        r_kvalid <= 1'b0;
                        r_kpc    <= '0;
                        r_ktc    <= '0;
                        r_kid    <= c_ID_NONE;
                        r_state  <= (!w_empty && bus.launch_en) ? ST_LOAD : ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (!bus.launch_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_id_avail) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef WARP_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (r_kvalid && bus.kernel_ready && (r_stat_issued != '1)) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if ((r_state == ST_STALL) && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign bus.stat_issued = r_stat_issued;
    assign bus.stat_stall  = r_stat_stall;
`endif

    assign bus.req_ready           = w_grant;
    assign bus.drop_pulse          = w_drop;
    assign bus.kernel_valid        = r_kvalid;
    assign bus.kernel_thread_count = r_ktc;
    assign bus.kernel_start_pc     = r_kpc;
    assign bus.kernel_warp_id      = r_kid;
    assign bus.queue_count         = r_count;
    assign bus.ids_busy            = r_ids_busy;
    assign bus.free_err            = r_free_err;

endmodule
`default_nettype wire

// File: tb/tb_warp_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_dispatch_scheduler
// Brief    : Directed scenarios plus randomized traffic against a queue/bitmap
//            reference model of the warp scheduler.
// Revision : 1.0
// ============================================================================
module tb_warp_dispatch_scheduler;
    localparam int NC = 4;
    localparam int QD = 8;
    localparam int NW = 15;
    localparam int TW = 3;
    localparam int PW = 32;
    localparam int IW = 4;
    localparam logic [IW-1:0] ID_NONE = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    warp_dispatch_scheduler_if #(
        .NUM_CORES(NC), .QUEUE_DEPTH(QD), .NUM_WARP_IDS(NW), .THREAD_W(TW), .PC_W(PW)
    ) bus ();

    warp_dispatch_scheduler #(
        .NUM_CORES(NC), .QUEUE_DEPTH(QD), .NUM_WARP_IDS(NW), .THREAD_W(TW), .PC_W(PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [TW-1:0] tc;
    } kern_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: pending kernels, busy IDs, sticky error, last granted core.
    kern_t mq[$];
    bit    mbusy [NW];
    bit    merr;
    int    rr_last;
    int    n_issued;
    kern_t cur_k;
    int    cur_id;
    bit    pv_valid;

    int            pend_grant;
    bit            pend_push;
    kern_t         pend_item;
    bit            pend_free;
    logic [IW-1:0] pend_fid;
    bit            pend_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NW; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < NW; i++) if (mbusy[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        merr     = 1'b0;
        rr_last  = NC - 1;
        n_issued = 0;
        pv_valid = 1'b0;
        cur_id   = -1;
    endtask

    task automatic set_idle();
        bus.req_valid        = '0;
        bus.req_thread_count = '0;
        bus.req_pc           = '0;
        bus.free_valid       = 1'b0;
        bus.free_warp_id     = '0;
    endtask

    task automatic set_req(input int core, input logic [PW-1:0] pc, input logic [TW-1:0] tc);
        bus.req_pc[core*PW +: PW]           = pc;
        bus.req_thread_count[core*TW +: TW] = tc;
    endtask

    // Before the edge: check the combinational grant against round-robin rules.
    task automatic pre();
        int            g;
        int            c;
        logic [NC-1:0] exp_rdy;
        logic [TW-1:0] tc_g;
        #1;
        g = -1;
        if (mq.size() < QD) begin
            for (int k = 1; k <= NC; k++) begin
                c = (rr_last + k) % NC;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        exp_rdy = '0;
        tc_g    = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            tc_g       = bus.req_thread_count[g*TW +: TW];
            pend_item.pc = bus.req_pc[g*PW +: PW];
            pend_item.tc = tc_g;
        end
        check("req_ready", bus.req_ready, exp_rdy);
        check("drop_pulse", bus.drop_pulse, (g >= 0) && (tc_g == '0));
        pend_grant = g;
        pend_push  = (g >= 0) && (tc_g != '0);
        pend_free  = bus.free_valid;
        pend_fid   = bus.free_warp_id;
        pend_ready = bus.kernel_ready;
    endtask

    // After the edge: advance the model and check registered outputs.
    task automatic post();
        bit    new_issue;
        int    aid;
        kern_t exp_k;
        @(posedge clk);
        #1;
        if (pend_grant >= 0) rr_last = pend_grant;
        new_issue = bus.kernel_valid && !pv_valid;
        aid = -1;
        if (new_issue) begin
            aid = lowest_free();
            if (mq.size() == 0) begin
                check("spurious_issue", bus.kernel_valid, 1'b0);
            end else if (aid < 0) begin
                check("issue_without_id", bus.kernel_valid, 1'b0);
            end else begin
                exp_k = mq.pop_front();
                check("issue_pc", bus.kernel_start_pc, exp_k.pc);
                check("issue_tc", bus.kernel_thread_count, exp_k.tc);
                check("issue_id", bus.kernel_warp_id, aid);
                cur_k  = exp_k;
                cur_id = aid;
                n_issued++;
            end
        end
        if (pend_push) mq.push_back(pend_item);
        if (pend_free) begin
            if (pend_fid < NW && mbusy[pend_fid]) mbusy[pend_fid] = 1'b0;
            else merr = 1'b1;
        end
        if (new_issue && aid >= 0) mbusy[aid] = 1'b1;

        if (pv_valid && pend_ready) check("valid_after_handshake", bus.kernel_valid, 1'b0);
        if (pv_valid && !pend_ready) begin
            check("valid_held", bus.kernel_valid, 1'b1);
            check("pc_held", bus.kernel_start_pc, cur_k.pc);
            check("tc_held", bus.kernel_thread_count, cur_k.tc);
            check("id_held", bus.kernel_warp_id, cur_id);
        end
        if (!bus.kernel_valid) begin
            check("idle_pc", bus.kernel_start_pc, 0);
            check("idle_tc", bus.kernel_thread_count, 0);
            check("idle_id", bus.kernel_warp_id, ID_NONE);
        end
        check("queue_count", bus.queue_count, mq.size());
        check("ids_busy", bus.ids_busy, busy_count());
        check("free_err", bus.free_err, merr);
        pv_valid = bus.kernel_valid;
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        check("rst_valid", bus.kernel_valid, 1'b0);
        check("rst_id", bus.kernel_warp_id, ID_NONE);
        check("rst_pc", bus.kernel_start_pc, 0);
        check("rst_tc", bus.kernel_thread_count, 0);
        check("rst_qcount", bus.queue_count, 0);
        check("rst_busy", bus.ids_busy, 0);
        check("rst_err", bus.free_err, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            r;
        int            bl[$];
        logic [NC-1:0] exp_g;

        set_idle();
        bus.launch_en    = 1'b0;
        bus.kernel_ready = 1'b0;
        model_reset();

        // Single request: latency and first ID.
        do_reset();
        bus.launch_en    = 1'b1;
        bus.kernel_ready = 1'b1;
        set_req(0, 32'h100, 3'd4);
        bus.req_valid = 4'b0001;
        pre();
        check("t1_grant", bus.req_ready, 4'b0001);
        post();
        check("t1_qcount", bus.queue_count, 1);
        bus.req_valid = '0;
        step();
        check("t1_load_cycle", bus.kernel_valid, 1'b0);
        step();
        check("t1_valid", bus.kernel_valid, 1'b1);
        check("t1_id", bus.kernel_warp_id, 0);
        check("t1_pc", bus.kernel_start_pc, 32'h100);
        check("t1_tc", bus.kernel_thread_count, 4);
        check("t1_busy", bus.ids_busy, 1);
        step();
        check("t1_taken", bus.kernel_valid, 1'b0);

        // All cores requesting: rotation and full queue.
        do_reset();
        bus.launch_en    = 1'b0;
        bus.kernel_ready = 1'b0;
        for (int k = 0; k < NC; k++) set_req(k, 32'h1000 + k, 3'd1);
        bus.req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            pre();
            check("t2_grant", bus.req_ready, exp_g);
            post();
        end
        check("t2_qcount", bus.queue_count, 8);
        pre();
        check("t2_full", bus.req_ready, 4'b0000);
        post();
        set_idle();

        // Exhaust the ID pool, stall, then free ID 6.
        do_reset();
        bus.launch_en    = 1'b1;
        bus.kernel_ready = 1'b1;
        bus.req_valid    = 4'b0001;
        for (int c = 0; c < 200 && n_issued < 15; c++) begin
            set_req(0, $urandom, 3'd2);
            step();
        end
        check("t3_issued", n_issued, 15);
        bus.req_valid = '0;
        for (int c = 0; c < 4; c++) step();
        check("t3_stall_valid", bus.kernel_valid, 1'b0);
        check("t3_all_busy", bus.ids_busy, 15);
        bus.free_valid   = 1'b1;
        bus.free_warp_id = 4'd6;
        step();
        bus.free_valid = 1'b0;
        for (int c = 0; c < 6 && !bus.kernel_valid; c++) step();
        check("t3_reissue_valid", bus.kernel_valid, 1'b1);
        check("t3_reissue_id", bus.kernel_warp_id, 6);

        // Freeing an idle ID raises the sticky error.
        do_reset();
        bus.free_valid   = 1'b1;
        bus.free_warp_id = 4'd3;
        step();
        bus.free_valid = 1'b0;
        check("t4_err", bus.free_err, 1'b1);
        check("t4_busy", bus.ids_busy, 0);
        step();
        step();
        check("t4_err_sticky", bus.free_err, 1'b1);

        // Zero-thread request is dropped.
        bus.launch_en = 1'b0;
        set_req(2, 32'h55, 3'd0);
        bus.req_valid = 4'b0100;
        pre();
        check("t5_grant", bus.req_ready, 4'b0100);
        check("t5_drop", bus.drop_pulse, 1'b1);
        post();
        check("t5_qcount", bus.queue_count, 0);
        bus.req_valid = '0;
        pre();
        check("t5_drop_clear", bus.drop_pulse, 1'b0);
        post();

        // Backpressure holds the kernel; reset discards everything.
        do_reset();
        bus.launch_en    = 1'b1;
        bus.kernel_ready = 1'b0;
        set_req(1, 32'h2000, 3'd7);
        set_req(3, 32'h3000, 3'd5);
        bus.req_valid = 4'b1010;
        step();
        step();
        bus.req_valid = '0;
        for (int c = 0; c < 10 && !bus.kernel_valid; c++) step();
        check("t6_valid", bus.kernel_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t6_hold_pc", bus.kernel_start_pc, 32'h2000);
            check("t6_hold_tc", bus.kernel_thread_count, 7);
            check("t6_hold_id", bus.kernel_warp_id, 0);
        end
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = NC'($urandom);
            for (int k = 0; k < NC; k++) set_req(k, $urandom, TW'($urandom));
            bus.launch_en    = ($urandom_range(0, 9) < 8);
            bus.kernel_ready = ($urandom_range(0, 9) < 6);
            bl.delete();
            for (int i = 0; i < NW; i++) if (mbusy[i]) bl.push_back(i);
            r = $urandom_range(0, 9);
            bus.free_valid = 1'b0;
            if (r < 3 && bl.size() > 0) begin
                bus.free_valid   = 1'b1;
                bus.free_warp_id = IW'(bl[$urandom_range(0, bl.size() - 1)]);
            end else if (r == 3) begin
                bus.free_valid   = 1'b1;
                bus.free_warp_id = IW'($urandom_range(0, 15));
            end
            step();
        end

        // Drain with IDs being returned.
        set_idle();
        bus.launch_en    = 1'b1;
        bus.kernel_ready = 1'b1;
        for (int c = 0; c < 300 && (mq.size() != 0 || bus.kernel_valid); c++) begin
            bl.delete();
            for (int i = 0; i < NW; i++) if (mbusy[i]) bl.push_back(i);
            bus.free_valid = 1'b0;
            if (bl.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.free_valid   = 1'b1;
                bus.free_warp_id = IW'(bl[$urandom_range(0, bl.size() - 1)]);
            end
            step();
        end
        bus.free_valid = 1'b0;
        check("drain_qcount", bus.queue_count, 0);
        check("drain_idle", bus.kernel_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/warp_dispatch_scheduler.md
# warp_dispatch_scheduler

Parametrised warp scheduler between the kernel-launch front end and the SIMD core array. Accepts per-core kernel requests (start PC and thread count) from NUM_CORES input channels through round-robin arbitration and buffers them in a FIFO. Allocates a warp ID from a configurable pool and issues kernels through a valid/ready handshake. Reclaims IDs when cores report warp completion.

## Interface
- NUM_CORES, 4, number of request channels
- QUEUE_DEPTH, 8, FIFO entries (power of two, ≥2)
- NUM_WARP_IDS, 15, allocatable IDs 0..NUM_WARP_IDS-1
- THREAD_W, 3, thread-count width
- PC_W, 32, start-PC width
- ID_W, $clog2(NUM_WARP_IDS+1), warp-ID width; all-ones = invalid ID

- clk  in  1  clock; one clock domain, everything on rising edge
- rst  in  1  synchronous, active-high reset
- launch_en  in  1  dispatch enable; ingest continues regardless
- req_valid  in  NUM_CORES  per-core request valid
- req_thread_count  in  NUM_CORES×THREAD_W  per-core thread count
- req_pc  in  NUM_CORES×PC_W  per-core start PC
- req_ready  out  NUM_CORES  one-hot grant; at most one bit high
- kernel_valid  out  1  issued kernel valid
- kernel_ready  in  1  downstream accepts
- kernel_thread_count  out  THREAD_W
- kernel_start_pc  out  PC_W
- kernel_warp_id  out  ID_W
- free_valid  in  1  warp completion strobe
- free_warp_id  in  ID_W  ID being returned
- queue_count  out  $clog2(QUEUE_DEPTH+1)  FIFO occupancy
- ids_busy  out  $clog2(NUM_WARP_IDS+1)  allocated-ID count
- drop_pulse  out  1  zero-thread request discarded this cycle
- free_err  out  1  sticky; illegal free seen

## Operation
- **Ingest.** Round-robin arbiter over req_valid, with priority starting at the core after the last granted core. Reset pointer is core 0. req_ready[i] is high iff core i wins and the queue is not full; it is combinational from req_valid.
- **Transfer.** A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - thread_count==0: request consumed and not queued; drop_pulse=1 for that cycle.
  - Otherwise: push {pc, count}.
- **FIFO.** Wrap-around pointers plus a count. Full: all req_ready low. Push and pop in the same cycle with count==QUEUE_DEPTH is legal (ready stays low on full, so this case never pushes).
- **ID pool.** Busy bitmap of NUM_WARP_IDS bits. Allocation takes the lowest clear bit.
- **Free.** free_valid with an ID that is busy clears its bit. An ID that is not busy, or one ≥NUM_WARP_IDS (including all-ones), leaves the bitmap unchanged and sets free_err until rst.
- **Simultaneous free and allocate.** A freed bit is not allocatable in the same cycle; it becomes allocatable from the next cycle.
- **FSM** (state register: IDLE, LOAD, ISSUE, STALL):
  - IDLE: kernel_valid=0. Go to LOAD when queue non-empty and launch_en.
  - LOAD: if a free ID exists, pop the head, latch {pc, count, lowest free ID} into the output register, set that busy bit, then go to ISSUE. Otherwise go to STALL.
  - ISSUE: kernel_valid=1 and outputs held stable. On kernel_ready: if the queue is non-empty and launch_en, go to LOAD; otherwise go to IDLE. Deasserting launch_en in ISSUE does not retract the issued kernel.
  - STALL: kernel_valid=0. Go to LOAD when a free ID is visible and launch_en; go to IDLE if launch_en drops.
- **Output values when kernel_valid=0:** kernel_thread_count=0, kernel_start_pc=0, kernel_warp_id=all-ones.
- **Counters.** ids_busy equals the popcount of the bitmap, maintained incrementally.

## Timing
- Reset (rst high at a rising edge), effective immediately:
  - state IDLE, FIFO empty, bitmap clear, arbiter pointer 0, free_err=0.
  - All outputs 0, except kernel_warp_id=all-ones.
  - Reset mid-operation discards queued and held kernels.
- **Latency.** Request accepted at edge T with launch_en=1, empty queue, free IDs, state IDLE:
  - FIFO holds the request after T.
  - LOAD during cycle T+1.
  - kernel_valid high after edge T+2.
- **Throughput.** One issue per 2 cycles (ISSUE→LOAD→ISSUE) with kernel_ready held high.
- **Reported values.** queue_count and ids_busy are registered and reflect state after the last edge.
- **Ordering.** FIFO order is preserved; ID order is lowest-free at LOAD time.

## Configuration
- WARP_SCHED_STATS_EN defined:
  - Adds outputs stat_issued (32-bit count of kernel_valid&&kernel_ready handshakes).
  - Adds stat_stall (32-bit count of cycles in STALL).
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then core 0 requests {pc=0x100, count=4} with launch_en=1, kernel_ready=1 → kernel_valid after 2 edges with warp_id=0, pc=0x100, count=4; then ids_busy=1.
- All 4 cores hold req_valid for 8 cycles, launch_en=0 → grants 0,1,2,3,0,1,2,3; queue_count=8; req_ready all low on cycle 9.
- Allocate 15 IDs; the 16th queued kernel enters STALL with kernel_valid=0. free_warp_id=6 → next kernel issues with warp_id=6.
- free_valid with warp_id=3 while 3 is not busy → free_err=1 and held; bitmap unchanged.
- Core 2 requests count=0 → drop_pulse for 1 cycle; queue_count unchanged.
- kernel_ready=0 for 5 cycles in ISSUE → outputs stable; assert rst → next cycle kernel_valid=0, kernel_warp_id=all-ones, queue_count=0.
